// File: rtl/pixel_queue_sc.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_queue_sc
//  Description : Single-clock pixel output queue. Buffers CHANNELS x
//                CHAN_WIDTH pixel components plus a POS_WIDTH position tag,
//                with fill level, programmable almost-full/almost-empty,
//                write acknowledge, over/underflow pulses and synchronous
//                flush. Synchronous-read storage suitable for block RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
module pixel_queue_sc #(
    parameter int ADDR_WIDTH        = 4,
    parameter int CHANNELS          = 4,
    parameter int CHAN_WIDTH        = 8,
    parameter int POS_WIDTH         = 3,
    parameter int PROG_FULL_THRESH  = 12,
    parameter int PROG_EMPTY_THRESH = 2,
    localparam int DW               = CHANNELS * CHAN_WIDTH + POS_WIDTH
) (
    input  logic                  clk,
    input  logic                  clk_en,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [DW-1:0]         din,
    input  logic                  wr_en,
    output logic                  wr_ack,
    output logic                  full,
    output logic                  almost_full,
    output logic                  overflow,
    input  logic                  rd_en,
    output logic [DW-1:0]         dout,
    output logic                  valid,
    output logic                  empty,
    output logic                  almost_empty,
    output logic                  underflow,
    output logic [ADDR_WIDTH:0]   level
);

    localparam int                c_depth_int = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] c_depth     = (ADDR_WIDTH + 1)'(c_depth_int);
    localparam logic [ADDR_WIDTH:0] c_full_thr  = (ADDR_WIDTH + 1)'(PROG_FULL_THRESH);
    localparam logic [ADDR_WIDTH:0] c_empty_thr = (ADDR_WIDTH + 1)'(PROG_EMPTY_THRESH);

    logic [DW-1:0]          r_mem [c_depth_int];
    logic [ADDR_WIDTH-1:0]  r_wr_ptr;
    logic [ADDR_WIDTH-1:0]  r_rd_ptr;
    logic [ADDR_WIDTH:0]    r_level;
    logic [DW-1:0]          r_dout;
    logic                   r_wr_ack;
    logic                   r_overflow;
    logic                   r_valid;
    logic                   r_underflow;

    logic                   w_we;
    logic                   w_re;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_wr_acc;
    logic                   w_rd_acc;

    // Status flags come from the level register only; pointers alone are
    // ambiguous when they are equal.
    assign w_full  = (r_level == c_depth);
    assign w_empty = (r_level == '0);

    // Gated strobes. A same-cycle read never makes room for a write on a full
    // queue, and a same-cycle write never bypasses to a read on an empty one.
    assign w_we     = wr_en & clk_en;
    assign w_re     = rd_en & clk_en;
    assign w_wr_acc = w_we & ~w_full  & ~flush & rst;
    assign w_rd_acc = w_re & ~w_empty & ~flush & rst;

    // Storage write port: no reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers, level, registered read data and pulse flags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_dout      <= '0;
            r_wr_ack    <= 1'b0;
            r_overflow  <= 1'b0;
            r_valid     <= 1'b0;
            r_underflow <= 1'b0;
        end else if (clk_en) begin
            if (flush) begin
                // dout deliberately holds its last value across a flush
                r_wr_ptr    <= '0;
                r_rd_ptr    <= '0;
                r_level     <= '0;
                r_wr_ack    <= 1'b0;
                r_overflow  <= 1'b0;
                r_valid     <= 1'b0;
                r_underflow <= 1'b0;
            end else begin
                r_wr_ack    <= w_wr_acc;
                r_overflow  <= w_we & w_full;
                r_valid     <= w_rd_acc;
                r_underflow <= w_re & w_empty;
                if (w_wr_acc) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_rd_acc) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                    r_dout   <= r_mem[r_rd_ptr];
                end
                if (w_wr_acc && !w_rd_acc) begin
                    r_level <= r_level + 1'b1;
                end else if (w_rd_acc && !w_wr_acc) begin
                    r_level <= r_level - 1'b1;
                end
            end
        end
    end

    assign wr_ack       = r_wr_ack;
    assign overflow     = r_overflow;
    assign valid        = r_valid;
    assign underflow    = r_underflow;
    assign dout         = r_dout;
    assign level        = r_level;
    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_level >= c_full_thr);
    assign almost_empty = (r_level <= c_empty_thr);

endmodule
`default_nettype wire
